// File: rtl/cipher_entry_pkg.sv
// rtl/cipher_entry_pkg.sv - shared state encoding, lamp indices and width helper for the cipher entry panel
package cipher_entry_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        IDLE     = 4'd0,
        KEY_IN   = 4'd1,
        KEY_SHOW = 4'd2,
        VAL_IN   = 4'd3,
        VAL_SHOW = 4'd4,
        READY    = 4'd5,
        RUN      = 4'd6,
        RESULT   = 4'd7
    } state_t;

    localparam int LED_KEY  = 0;
    localparam int LED_VAL  = 1;
    localparam int LED_BUSY = 2;
    localparam int LED_DONE = 3;
    localparam int NUM_LEDS = 4;

    function automatic int sel_width(input int nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

endpackage

// File: rtl/cipher_entry_if.sv
// rtl/cipher_entry_if.sv - panel buttons, cipher core handshake and display signals
interface cipher_entry_if #(
    parameter int DATA_W  = 64,
    parameter int CHUNK_W = 16
);
    import cipher_entry_pkg::*;

    localparam int NCHUNK = DATA_W / CHUNK_W;
    localparam int SEL_W  = sel_width(NCHUNK);

    logic               send_n;
    logic               next_n;
    logic               go_n;
    logic               mode;
    logic [CHUNK_W-1:0] user_in;
    logic [SEL_W-1:0]   sel;
    logic               core_start;
    logic               core_mode;
    logic [DATA_W-1:0]  core_key;
    logic [DATA_W-1:0]  core_din;
    logic               core_done;
    logic [DATA_W-1:0]  core_dout;
    logic [CHUNK_W-1:0] disp;
    logic               key_led;
    logic               val_led;
    logic               busy_led;
    logic               done_led;

    // Panel and cipher core side
    modport master (
        output send_n, next_n, go_n, mode, user_in, sel, core_done, core_dout,
        input  core_start, core_mode, core_key, core_din, disp,
               key_led, val_led, busy_led, done_led
    );

    // Entry controller side
    modport slave (
        input  send_n, next_n, go_n, mode, user_in, sel, core_done, core_dout,
        output core_start, core_mode, core_key, core_din, disp,
               key_led, val_led, busy_led, done_led
    );

endinterface

// File: rtl/btn_event.sv
// rtl/btn_event.sv - two-flop synchronizer plus history flop giving one event per button press
module btn_event (
    input  logic clk,
    input  logic rst,
    input  logic i_btn_n,
    output logic o_event
);

    logic r_sync1;
    logic r_sync2;
    logic r_hist;

    // Idle level of an active-low button is 1, so reset parks every flop high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_hist  <= 1'b1;
        end else begin
            r_sync1 <= i_btn_n;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    // Falling edge of the synchronized level; a held button fires once
    assign o_event = r_hist & ~r_sync2;

endmodule

// File: rtl/cipher_entry_fsm.sv
// rtl/cipher_entry_fsm.sv - key/value entry, launch and result display controller (optional CIPHER_ENTRY_EDIT_EN)
module cipher_entry_fsm
    import cipher_entry_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int CHUNK_W = 16
) (
    input logic           clk,
    input logic           rst,
    cipher_entry_if.slave bus
);

    localparam int NCHUNK = DATA_W / CHUNK_W;
    localparam int SEL_W  = sel_width(NCHUNK);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NCHUNK - 1);

`ifdef CIPHER_ENTRY_EDIT_EN
    localparam bit EDIT_EN = 1'b1;
`else
    localparam bit EDIT_EN = 1'b0;
`endif

    generate
        if ((DATA_W % CHUNK_W) != 0 || NCHUNK < 1) begin : g_bad_width
            $error("cipher_entry_fsm: DATA_W must be a non-zero multiple of CHUNK_W");
        end
    endgenerate

    function automatic logic [CHUNK_W-1:0] get_chunk(input logic [DATA_W-1:0] v,
                                                      input logic [SEL_W-1:0]  pos);
        return CHUNK_W'(v >> (CHUNK_W * int'(pos)));
    endfunction

    function automatic logic [DATA_W-1:0] put_chunk(input logic [DATA_W-1:0]  v,
                                                     input logic [SEL_W-1:0]   pos,
                                                     input logic [CHUNK_W-1:0] word);
        logic [DATA_W-1:0] mask;
        logic [DATA_W-1:0] ins;
        mask = DATA_W'({CHUNK_W{1'b1}}) << (CHUNK_W * int'(pos));
        ins  = DATA_W'(word) << (CHUNK_W * int'(pos));
        return (v & ~mask) | ins;
    endfunction

    state_t               r_state;
    state_t               w_next;
    logic [SEL_W-1:0]     r_idx;
    logic [DATA_W-1:0]    r_key;
    logic [DATA_W-1:0]    r_val;
    logic [DATA_W-1:0]    r_res;
    logic                 r_core_start;
    logic                 r_core_mode;
    logic [CHUNK_W-1:0]   r_disp;
    logic [CHUNK_W-1:0]   w_disp;
    logic [NUM_LEDS-1:0]  w_leds;

    logic w_send_ev, w_next_ev, w_go_ev;
    logic w_key_wr, w_val_wr, w_key_edit, w_val_edit;
    logic w_idx_inc, w_idx_clr, w_launch, w_res_wr;

    btn_event u_send (.clk(clk), .rst(rst), .i_btn_n(bus.send_n), .o_event(w_send_ev));
    btn_event u_next (.clk(clk), .rst(rst), .i_btn_n(bus.next_n), .o_event(w_next_ev));
    btn_event u_go   (.clk(clk), .rst(rst), .i_btn_n(bus.go_n),   .o_event(w_go_ev));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next state and datapath strobes; each state listens to its own button only
    always_comb begin
        w_next     = r_state;
        w_key_wr   = 1'b0;
        w_val_wr   = 1'b0;
        w_key_edit = 1'b0;
        w_val_edit = 1'b0;
        w_idx_inc  = 1'b0;
        w_idx_clr  = 1'b0;
        w_launch   = 1'b0;
        w_res_wr   = 1'b0;
        case (r_state)
            IDLE: w_next = KEY_IN;
            KEY_IN: if (w_send_ev) begin
                w_key_wr = 1'b1;
                if (r_idx == LAST_IDX) begin
                    w_idx_clr = 1'b1;
                    w_next    = KEY_SHOW;
                end else begin
                    w_idx_inc = 1'b1;
                end
            end
            KEY_SHOW: if (w_next_ev) begin
                w_idx_clr = 1'b1;
                w_next    = VAL_IN;
            end else if (w_send_ev) begin
                w_key_edit = EDIT_EN;
            end
            VAL_IN: if (w_send_ev) begin
                w_val_wr = 1'b1;
                if (r_idx == LAST_IDX) begin
                    w_idx_clr = 1'b1;
                    w_next    = VAL_SHOW;
                end else begin
                    w_idx_inc = 1'b1;
                end
            end
            VAL_SHOW: if (w_next_ev) begin
                w_idx_clr = 1'b1;
                w_next    = READY;
            end else if (w_send_ev) begin
                w_val_edit = EDIT_EN;
            end
            READY: if (w_go_ev) begin
                w_launch = 1'b1;
                w_next   = RUN;
            end
            RUN: if (bus.core_done) begin
                w_res_wr = 1'b1;
                w_next   = RESULT;
            end
            RESULT: if (w_next_ev) begin
                w_idx_clr = 1'b1;
                w_next    = VAL_IN;
            end
            default: begin
                w_idx_clr = 1'b1;
                w_next    = IDLE;
            end
        endcase
    end

    // Chunk index: entry order is most significant chunk first
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            r_idx <= '0;
        else if (w_idx_clr) r_idx <= '0;
        else if (w_idx_inc) r_idx <= r_idx + SEL_W'(1);
    end

    // Key, value and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key <= '0;
            r_val <= '0;
            r_res <= '0;
        end else begin
            if (w_key_wr)        r_key <= put_chunk(r_key, LAST_IDX - r_idx, bus.user_in);
            else if (w_key_edit) r_key <= put_chunk(r_key, bus.sel, bus.user_in);
            if (w_val_wr)        r_val <= put_chunk(r_val, LAST_IDX - r_idx, bus.user_in);
            else if (w_val_edit) r_val <= put_chunk(r_val, bus.sel, bus.user_in);
            if (w_res_wr)        r_res <= bus.core_dout;
        end
    end

    // Launch pulse lasts exactly the first RUN cycle; mode is frozen at launch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_core_start <= 1'b0;
            r_core_mode  <= 1'b0;
        end else begin
            r_core_start <= w_launch;
            if (w_launch) r_core_mode <= bus.mode;
        end
    end

    // Display source selected by the current state
    always_comb begin
        w_disp = '0;
        case (r_state)
            KEY_IN, VAL_IN: w_disp = bus.user_in;
            KEY_SHOW:       w_disp = get_chunk(r_key, bus.sel);
            VAL_SHOW:       w_disp = get_chunk(r_val, bus.sel);
            RESULT:         w_disp = get_chunk(r_res, bus.sel);
            default:        w_disp = '0;
        endcase
    end

    // Registered display word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_disp <= '0;
        else     r_disp <= w_disp;
    end

    // Status lamps decoded from the state register
    always_comb begin
        w_leds           = '0;
        w_leds[LED_KEY]  = (r_state == KEY_SHOW);
        w_leds[LED_VAL]  = (r_state == VAL_SHOW);
        w_leds[LED_BUSY] = (r_state == RUN);
        w_leds[LED_DONE] = (r_state == RESULT);
    end

    assign bus.core_start = r_core_start;
    assign bus.core_mode  = r_core_mode;
    assign bus.core_key   = r_key;
    assign bus.core_din   = r_val;
    assign bus.disp       = r_disp;
    assign bus.key_led    = w_leds[LED_KEY];
    assign bus.val_led    = w_leds[LED_VAL];
    assign bus.busy_led   = w_leds[LED_BUSY];
    assign bus.done_led   = w_leds[LED_DONE];

endmodule

// File: doc/cipher_entry_fsm.md
CIPHER_ENTRY_FSM -- requirements
Module: cipher_entry_fsm

Interface
REQ-001 SHALL have parameter DATA_W, default 64, giving key/value/result block width in bits.
REQ-002 SHALL have parameter CHUNK_W, default 16, giving switch word width; NCHUNK = DATA_W/CHUNK_W; SEL_W = max(1, clog2(NCHUNK)).
REQ-003 clk  in  1  single clock, all logic on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 send_n  in  1  active-low button, capture one chunk.
REQ-006 next_n  in  1  active-low button, advance from a display state.
REQ-007 go_n  in  1  active-low button, launch cipher operation.
REQ-008 mode  in  1  0 = encrypt, 1 = decrypt; sampled at launch.
REQ-009 user_in  in  CHUNK_W  switch word.
REQ-010 sel  in  SEL_W  display chunk select; 0 = least significant chunk.
REQ-011 core_start  out  1  one-cycle launch pulse to cipher core.
REQ-012 core_mode  out  1  latched mode.
REQ-013 core_key, core_din  out  DATA_W  key and value registers.
REQ-014 core_done  in  1  one-cycle completion pulse from core.
REQ-015 core_dout  in  DATA_W  core result, valid with core_done.
REQ-016 disp  out  CHUNK_W  word for hex display.
REQ-017 key_led, val_led, busy_led, done_led  out  1 each  status lamps.

Function
REQ-018 Each button SHALL pass a 2-flop synchronizer plus a history flop; a press event is one cycle long, on the synchronized falling edge; a held button gives exactly one event.
REQ-019 States SHALL be IDLE, KEY_IN, KEY_SHOW, VAL_IN, VAL_SHOW, READY, RUN, RESULT; IDLE -> KEY_IN unconditionally on the next cycle.
REQ-020 In KEY_IN/VAL_IN a send event SHALL write user_in to chunk NCHUNK-1-idx (MS chunk first), then increment idx; the event on idx = NCHUNK-1 SHALL clear idx and go to KEY_SHOW/VAL_SHOW.
REQ-021 A next event SHALL move KEY_SHOW -> VAL_IN, VAL_SHOW -> READY, and RESULT -> VAL_IN; the key is retained and idx is cleared.
REQ-022 A go event in READY SHALL latch mode into core_mode, pulse core_start for exactly the next cycle, and enter RUN.
REQ-023 In RUN, core_done SHALL latch core_dout into the result register and enter RESULT in the same edge; all buttons are ignored in RUN.
REQ-024 core_done outside RUN SHALL be ignored.
REQ-025 Button events not listed for the current state SHALL be ignored; simultaneous events SHALL be resolved by state, since only one button is meaningful per state.
REQ-026 disp SHALL show:
- user_in in the *_IN states;
- chunk sel of key, value or result in KEY_SHOW, VAL_SHOW and RESULT;
- zero in IDLE, READY and RUN;
- disp is registered, 1-cycle latency.
REQ-027 Lamps: key_led = KEY_SHOW, val_led = VAL_SHOW, busy_led = RUN, done_led = RESULT.
REQ-028 An unreachable state encoding SHALL return to IDLE on the next edge.

Reset
REQ-029 rst SHALL asynchronously force:
- state IDLE, idx 0;
- key, value and result to 0;
- all outputs 0, core_start included;
- synchronizer flops to 1 (released).
REQ-030 rst during RUN SHALL abandon the operation; a later core_done SHALL be ignored.

Configuration
REQ-031 With CIPHER_ENTRY_EDIT_EN defined:
- a send event in KEY_SHOW/VAL_SHOW SHALL overwrite chunk sel with user_in and remain in the same state.
REQ-032 Without it, that send event SHALL be ignored.

Structure
REQ-033 The state enum, state encoding width and lamp index constants SHALL live in shared package cipher_entry_pkg.
REQ-034 The synchronizer/edge detector SHALL be sub-module btn_event, instantiated three times.
REQ-035 A DATA_W not a multiple of CHUNK_W SHALL raise an elaboration error.

Verification (DATA_W=64, CHUNK_W=16)
REQ-036 Send presses 0123, 4567, 89AB, CDEF:
- core_key = 0x0123456789ABCDEF, key_led = 1;
- sel = 3 gives disp = 0x0123 after 1 cycle.
REQ-037 send_n held low for 50 cycles in KEY_IN:
- exactly one chunk written;
- capture on the 3rd rising edge after the pin falls.
REQ-038 Value entered, next pressed, go pressed with mode = 1:
- core_start high for exactly 1 cycle, core_mode = 1;
- core_done with core_dout = 0xFEDCBA9876543210 gives done_led = 1, and sel = 0 gives disp = 0x3210.
REQ-039 rst asserted mid-RUN:
- all outputs 0 immediately, state IDLE;
- subsequent core_done pulse gives no RESULT.
REQ-040 In RESULT, next then four sends of 1111:
- core_din = 0x1111111111111111;
- core_key unchanged.
REQ-041 With CIPHER_ENTRY_EDIT_EN, in KEY_SHOW with sel = 1 and user_in = AAAA, one send:
- core_key[31:16] = 0xAAAA, state stays KEY_SHOW.
- Without the macro, core_key is unchanged.
